verifica_senha_multi: RTL and testbench

- Parametrised successor to the single-password checker in the electronic lock.
- Compares one entered digit sequence against N_SENHAS stored passwords, e.g. master plus user slots.
- Each stored password may appear anywhere inside the entered sequence, so extra digits before or after it are tolerated (anti-peeping).
- Sits between keypad capture and the lock FSM; reports pass/fail and which slot matched.

---
 rtl/verifica_senha_multi.sv | 148 ++++++++++++++
 tb/tb_verifica_senha_multi.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/verifica_senha_multi.sv
// Multi-slot password checker: searches each enabled stored password as a
// contiguous run inside the entered digit sequence, one (slot, offset) per cycle.
module verifica_senha_multi #(
    parameter int unsigned MAX_DIGITS = 12,
    parameter int unsigned MIN_LEN    = 4,
    parameter int unsigned N_SENHAS   = 2,
    parameter int unsigned IDX_W      = (N_SENHAS > 1) ? $clog2(N_SENHAS) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             valid_in,
    input  logic [4*MAX_DIGITS-1:0]          senha_teste,
    input  logic [4*MAX_DIGITS*N_SENHAS-1:0] senhas_reais,
    input  logic [N_SENHAS-1:0]              slot_en,
    output logic                             busy,
    output logic                             done,
    output logic                             senha_ok,
    output logic [IDX_W-1:0]                 match_idx
);

    localparam int unsigned DW = 4 * MAX_DIGITS;
    localparam int unsigned CW = $clog2(MAX_DIGITS + 1);

    typedef enum logic [1:0] {IDLE, MEASURE, SCAN, DONE} state_t;

    state_t                         r_state;
    logic [DW-1:0]                  r_teste;
    logic [DW*N_SENHAS-1:0]         r_reais;
    logic [N_SENHAS-1:0]            r_en;
    logic [CW-1:0]                  r_lt;
    logic [CW-1:0]                  r_k;
    logic [IDX_W-1:0]               r_c;

    logic [DW-1:0]                  w_slot;
    logic                           w_en;
    logic [CW-1:0]                  w_lc;
    logic                           w_valid;
    logic                           w_match;
    logic                           w_last_k;
    logic                           w_last_c;

    // Length = index of the first 4'hF terminator, or MAX_DIGITS if none.
    function automatic logic [CW-1:0] seq_len(input logic [DW-1:0] s);
        logic [CW-1:0] len;
        len = CW'(MAX_DIGITS);
        for (int i = int'(MAX_DIGITS) - 1; i >= 0; i--) begin
            if (s[4*i +: 4] == 4'hF) len = CW'(i);
        end
        return len;
    endfunction

    always_comb begin
        w_slot = r_reais[DW-1:0];
        w_en   = r_en[0];
        for (int c = 0; c < int'(N_SENHAS); c++) begin
            if (r_c == IDX_W'(c)) begin
                w_slot = r_reais[c*DW +: DW];
                w_en   = r_en[c];
            end
        end
    end

    assign w_lc     = seq_len(w_slot);
    assign w_valid  = w_en && (w_lc >= CW'(MIN_LEN)) && (w_lc <= r_lt);
    assign w_last_k = (r_k == (r_lt - w_lc));
    assign w_last_c = (r_c == IDX_W'(N_SENHAS - 1));

    // Stored digits 0..Lc-1 against entered digits k..k+Lc-1.
    always_comb begin
        int unsigned j;
        w_match = 1'b1;
        j       = 0;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            if (CW'(i) < w_lc) begin
                j = int'(r_k) + i;
                if (j < MAX_DIGITS) begin
                    if (w_slot[4*i +: 4] != r_teste[4*j +: 4]) w_match = 1'b0;
                end else begin
                    w_match = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_teste   <= '0;
            r_reais   <= '0;
            r_en      <= '0;
            r_lt      <= '0;
            r_k       <= '0;
            r_c       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            senha_ok  <= 1'b0;
            match_idx <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (valid_in) begin
                        r_teste   <= senha_teste;
                        r_reais   <= senhas_reais;
                        r_en      <= slot_en;
                        senha_ok  <= 1'b0;
                        match_idx <= '0;
                        busy      <= 1'b1;
                        r_state   <= MEASURE;
                    end else begin
                        r_state   <= IDLE;
                    end
                end
                MEASURE: begin
                    r_lt    <= seq_len(r_teste);
                    r_c     <= '0;
                    r_k     <= '0;
                    r_state <= SCAN;
                end
                SCAN: begin
                    if (w_valid && w_match) begin
                        senha_ok  <= 1'b1;
                        match_idx <= r_c;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        r_state   <= DONE;
                    end else if (!w_valid || w_last_k) begin
                        // Slot exhausted or invalid: advance slot or give up.
                        if (w_last_c) begin
                            senha_ok  <= 1'b0;
                            match_idx <= '0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            r_state   <= DONE;
                        end else begin
                            r_c <= IDX_W'(r_c + 1'b1);
                            r_k <= '0;
                        end
                    end else begin
                        r_k <= CW'(r_k + 1'b1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_verifica_senha_multi.sv
// Directed bench for verifica_senha_multi: latency, result, hold, abort and
// back-to-back acceptance with MAX_DIGITS=12, N_SENHAS=2.
module tb_verifica_senha_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [47:0] senha_teste;
    logic [95:0] senhas_reais;
    logic [1:0]  slot_en;
    logic        busy;
    logic        done;
    logic        senha_ok;
    logic [0:0]  match_idx;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    verifica_senha_multi #(
        .MAX_DIGITS(12), .MIN_LEN(4), .N_SENHAS(2), .IDX_W(1)
    ) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in),
        .senha_teste(senha_teste), .senhas_reais(senhas_reais), .slot_en(slot_en),
        .busy(busy), .done(done), .senha_ok(senha_ok), .match_idx(match_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Digits written most-significant-first as they are typed; rest filled with F.
    function automatic logic [47:0] seq(input logic [47:0] v, input int n);
        logic [47:0] r;
        r = '1;
        for (int i = 0; i < n; i++) r[4*i +: 4] = v[4*(n-1-i) +: 4];
        return r;
    endfunction

    task automatic start(input logic [47:0] t, input logic [47:0] s0,
                         input logic [47:0] s1, input logic [1:0] en);
        senha_teste  = t;
        senhas_reais = {s1, s0};
        slot_en      = en;
        valid_in     = 1'b1;
        @(posedge clk);
        #1 valid_in  = 1'b0;
    endtask

    // Observes edges after the accepting edge; done must first be seen at edge 2+E.
    task automatic wait_done(input int n0, input int e, input logic ok,
                             input logic idx, input string tag);
        int n;
        bit seen;
        n    = n0;
        seen = 1'b0;
        while (!seen && n < 2 + e + 6) begin
            @(negedge clk);
            n++;
            if (done) seen = 1'b1;
            else if (n < 2 + e) chk({tag, ":busy"}, 48'(busy), 48'd1);
        end
        chk({tag, ":done_seen"}, 48'(seen), 48'd1);
        if (seen) begin
            chk({tag, ":done_edge"}, 48'(n), 48'(2 + e));
            chk({tag, ":ok"}, 48'(senha_ok), 48'(ok));
            chk({tag, ":idx"}, 48'(match_idx), 48'(idx));
            chk({tag, ":busy_done"}, 48'(busy), 48'd0);
        end
    endtask

    task automatic hold(input logic ok, input logic idx, input string tag);
        senha_teste = '0;
        @(negedge clk);
        chk({tag, ":pulse_end"}, 48'(done), 48'd0);
        chk({tag, ":hold_ok"}, 48'(senha_ok), 48'(ok));
        chk({tag, ":hold_idx"}, 48'(match_idx), 48'(idx));
    endtask

    initial begin
        rst          = 1'b0;
        valid_in     = 1'b0;
        senha_teste  = '1;
        senhas_reais = '1;
        slot_en      = 2'b11;
        #12;
        chk("rst:busy", 48'(busy), 48'd0);
        chk("rst:done", 48'(done), 48'd0);
        chk("rst:ok", 48'(senha_ok), 48'd0);
        chk("rst:idx", 48'(match_idx), 48'd0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);

        start(seq(48'h1234, 4), seq(48'h1234, 4), '1, 2'b11);
        wait_done(0, 1, 1'b1, 1'b0, "t1_exact");
        hold(1'b1, 1'b0, "t1");

        start(seq(48'h9912345, 7), seq(48'h1234, 4), '1, 2'b11);
        wait_done(0, 3, 1'b1, 1'b0, "t2_embed");
        hold(1'b1, 1'b0, "t2");

        start(seq(48'h004321, 6), seq(48'h5678, 4), seq(48'h4321, 4), 2'b11);
        wait_done(0, 6, 1'b1, 1'b1, "t3_slot1");
        hold(1'b1, 1'b1, "t3");

        start(seq(48'h22222, 5), seq(48'h1111, 4), seq(48'h123, 3), 2'b11);
        wait_done(0, 3, 1'b0, 1'b0, "t4_reject");
        hold(1'b0, 1'b0, "t4");

        start(seq(48'h22222, 5), seq(48'h22222, 5), seq(48'h123, 3), 2'b10);
        wait_done(0, 2, 1'b0, 1'b0, "t4_disabled");
        hold(1'b0, 1'b0, "t4b");

        start(seq(48'h12, 2), seq(48'h1234, 4), seq(48'h5678, 4), 2'b11);
        wait_done(0, 2, 1'b0, 1'b0, "t5_short");
        hold(1'b0, 1'b0, "t5");

        // Second request mid-scan with different inputs must be ignored.
        start(seq(48'h004321, 6), seq(48'h5678, 4), seq(48'h4321, 4), 2'b11);
        repeat (3) @(negedge clk);
        senha_teste  = seq(48'h5678, 4);
        senhas_reais = '1;
        valid_in     = 1'b1;
        @(posedge clk);
        #1 valid_in  = 1'b0;
        wait_done(3, 6, 1'b1, 1'b1, "t6_ignore");
        hold(1'b1, 1'b1, "t6a");

        // Asynchronous abort mid-scan.
        start(seq(48'h004321, 6), seq(48'h5678, 4), seq(48'h4321, 4), 2'b11);
        repeat (3) @(negedge clk);
        chk("t6_rst:busy_before", 48'(busy), 48'd1);
        rst = 1'b0;
        #1;
        chk("t6_rst:busy", 48'(busy), 48'd0);
        chk("t6_rst:done", 48'(done), 48'd0);
        chk("t6_rst:ok", 48'(senha_ok), 48'd0);
        chk("t6_rst:idx", 48'(match_idx), 48'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t6_rst:no_done", 48'(done), 48'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        start(seq(48'h9912345, 7), seq(48'h1234, 4), '1, 2'b11);
        wait_done(0, 3, 1'b1, 1'b0, "t6_after_rst");

        // Accept during the DONE cycle.
        start(seq(48'h004321, 6), seq(48'h5678, 4), seq(48'h4321, 4), 2'b11);
        wait_done(0, 6, 1'b1, 1'b1, "t6_done_accept");
        start(seq(48'h12, 2), seq(48'h1234, 4), seq(48'h5678, 4), 2'b11);
        wait_done(0, 2, 1'b0, 1'b0, "t6_b2b");
        hold(1'b0, 1'b0, "t6c");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
